// File: rtl/alu_defs_pkg.sv
// Shared ALU issue definitions: alu_op bit indices, LA32 opcode/func fields,
// the decoder output record and the register-hazard helper.
package alu_defs_pkg;

  localparam int ALU_OP_W    = 12;
  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_SLT  = 2;
  localparam int ALU_OP_SLTU = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_NOR  = 5;
  localparam int ALU_OP_OR   = 6;
  localparam int ALU_OP_XOR  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRL  = 9;
  localparam int ALU_OP_SRA  = 10;
  localparam int ALU_OP_LUI  = 11;

  localparam logic [9:0] OP_3R_HI   = 10'b0;
  localparam logic [1:0] OP_3R_MID  = 2'b01;
  localparam logic [5:0] OP_I_HI    = 6'b0;
  localparam logic [3:0] OP_SHI_MID = 4'b0001;
  localparam logic [1:0] OP_SHI_LO  = 2'b00;

  localparam logic [4:0] F_ADD  = 5'b00000;
  localparam logic [4:0] F_SUB  = 5'b00010;
  localparam logic [4:0] F_SLT  = 5'b00100;
  localparam logic [4:0] F_SLTU = 5'b00101;
  localparam logic [4:0] F_NOR  = 5'b01000;
  localparam logic [4:0] F_AND  = 5'b01001;
  localparam logic [4:0] F_OR   = 5'b01010;
  localparam logic [4:0] F_XOR  = 5'b01011;
  localparam logic [4:0] F_SLL  = 5'b01110;
  localparam logic [4:0] F_SRL  = 5'b01111;
  localparam logic [4:0] F_SRA  = 5'b10000;

  localparam logic [4:0] F_SLLI = 5'b00001;
  localparam logic [4:0] F_SRLI = 5'b01001;
  localparam logic [4:0] F_SRAI = 5'b10001;

  localparam logic [3:0] OPI_SLTI  = 4'b1000;
  localparam logic [3:0] OPI_SLTUI = 4'b1001;
  localparam logic [3:0] OPI_ADDI  = 4'b1010;
  localparam logic [3:0] OPI_ANDI  = 4'b1101;
  localparam logic [3:0] OPI_ORI   = 4'b1110;
  localparam logic [3:0] OPI_XORI  = 4'b1111;

  localparam logic [6:0] OP_LU12I     = 7'b0001010;
  localparam logic [6:0] OP_PCADDU12I = 7'b0001110;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic [31:0]         imm;
    logic                src1_pc;
    logic                src2_imm;
    logic                rj_used;
    logic                rk_used;
    logic                gr_we;
    logic                ine;
  } dec_t;

  // Register 0 is hardwired, so it can never create a dependency.
  function automatic logic reg_hit(input logic [4:0] src, input logic [4:0] dst);
    return (src != 5'd0) && (src == dst);
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Decode-to-EX issue bus: valid/allowin handshake plus the ALU operand bundle.
interface alu_issue_stage_if
  import alu_defs_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int NREG_LOG = 5
);
  logic                ds_to_es_valid;
  logic                es_allowin;
  logic [ALU_OP_W-1:0] alu_op;
  logic [PC_W-1:0]     alu_src1;
  logic [PC_W-1:0]     alu_src2;
  logic [PC_W-1:0]     ds_pc;
  logic [NREG_LOG-1:0] dest;
  logic                gr_we;
  logic                inst_ine;

  modport master (
    output ds_to_es_valid, alu_op, alu_src1, alu_src2, ds_pc, dest, gr_we, inst_ine,
    input  es_allowin
  );

  modport slave (
    input  ds_to_es_valid, alu_op, alu_src1, alu_src2, ds_pc, dest, gr_we, inst_ine,
    output es_allowin
  );
endinterface

// File: rtl/alu_op_decoder.sv
// Combinational LA32 integer-ALU decoder: one-hot alu_op, immediate,
// operand selects, source usage, write enable and unsupported flag.
module alu_op_decoder
  import alu_defs_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [31:0] si12, ui12, ui5, si20;
  assign si12 = {{20{inst[21]}}, inst[21:10]};
  assign ui12 = {20'd0, inst[21:10]};
  assign ui5  = {27'd0, inst[14:10]};
  assign si20 = {inst[24:5], 12'd0};

  always_comb begin
    dec = '0;
    if (inst[31:22] == OP_3R_HI && inst[21:20] == OP_3R_MID) begin
      dec.rk_used = 1'b1;
      case (inst[19:15])
        F_ADD:   dec.alu_op[ALU_OP_ADD]  = 1'b1;
        F_SUB:   dec.alu_op[ALU_OP_SUB]  = 1'b1;
        F_SLT:   dec.alu_op[ALU_OP_SLT]  = 1'b1;
        F_SLTU:  dec.alu_op[ALU_OP_SLTU] = 1'b1;
        F_NOR:   dec.alu_op[ALU_OP_NOR]  = 1'b1;
        F_AND:   dec.alu_op[ALU_OP_AND]  = 1'b1;
        F_OR:    dec.alu_op[ALU_OP_OR]   = 1'b1;
        F_XOR:   dec.alu_op[ALU_OP_XOR]  = 1'b1;
        F_SLL:   dec.alu_op[ALU_OP_SLL]  = 1'b1;
        F_SRL:   dec.alu_op[ALU_OP_SRL]  = 1'b1;
        F_SRA:   dec.alu_op[ALU_OP_SRA]  = 1'b1;
        default: ;
      endcase
    end else if (inst[31:26] == OP_I_HI && inst[25:22] == OP_SHI_MID &&
                 inst[21:20] == OP_SHI_LO) begin
      dec.src2_imm = 1'b1;
      dec.imm      = ui5;
      case (inst[19:15])
        F_SLLI:  dec.alu_op[ALU_OP_SLL] = 1'b1;
        F_SRLI:  dec.alu_op[ALU_OP_SRL] = 1'b1;
        F_SRAI:  dec.alu_op[ALU_OP_SRA] = 1'b1;
        default: ;
      endcase
    end else if (inst[31:26] == OP_I_HI) begin
      dec.src2_imm = 1'b1;
      dec.imm      = si12;
      case (inst[25:22])
        OPI_SLTI:  dec.alu_op[ALU_OP_SLT]  = 1'b1;
        OPI_SLTUI: dec.alu_op[ALU_OP_SLTU] = 1'b1;
        OPI_ADDI:  dec.alu_op[ALU_OP_ADD]  = 1'b1;
        OPI_ANDI:  begin dec.alu_op[ALU_OP_AND] = 1'b1; dec.imm = ui12; end
        OPI_ORI:   begin dec.alu_op[ALU_OP_OR]  = 1'b1; dec.imm = ui12; end
        OPI_XORI:  begin dec.alu_op[ALU_OP_XOR] = 1'b1; dec.imm = ui12; end
        default: ;
      endcase
    end else if (inst[31:25] == OP_LU12I) begin
      dec.alu_op[ALU_OP_LUI] = 1'b1;
      dec.src2_imm           = 1'b1;
      dec.imm                = si20;
    end else if (inst[31:25] == OP_PCADDU12I) begin
      dec.alu_op[ALU_OP_ADD] = 1'b1;
      dec.src1_pc            = 1'b1;
      dec.src2_imm           = 1'b1;
      dec.imm                = si20;
    end
    // Usage flags only count for recognised encodings so junk never stalls.
    dec.ine     = ~|dec.alu_op;
    dec.rj_used = ~dec.ine & ~dec.alu_op[ALU_OP_LUI] & ~dec.src1_pc;
    dec.rk_used = dec.rk_used & ~dec.ine;
    dec.gr_we   = ~dec.ine & (inst[4:0] != 5'd0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the EX ALU with RAW hazard handling.
// Optional macro FORWARD_EN: bypass from EX/MEM/WB instead of stalling.
module alu_issue_stage
  import alu_defs_pkg::*;
#(
  parameter int PC_W     = 32,
  parameter int NREG_LOG = 5
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                fs_to_ds_valid,
  output logic                ds_allowin,
  input  logic [31:0]         fs_inst,
  input  logic [PC_W-1:0]     fs_pc,
  input  logic                flush,
  output logic [NREG_LOG-1:0] rf_raddr1,
  output logic [NREG_LOG-1:0] rf_raddr2,
  input  logic [31:0]         rf_rdata1,
  input  logic [31:0]         rf_rdata2,
  input  logic [NREG_LOG-1:0] ex_dest,
  input  logic [NREG_LOG-1:0] mem_dest,
  input  logic [NREG_LOG-1:0] wb_dest,
  input  logic [31:0]         ex_fwd,
  input  logic [31:0]         mem_fwd,
  input  logic [31:0]         wb_fwd,
  alu_issue_stage_if.master   es
);

  logic            ds_valid;
  logic [31:0]     ds_inst;
  logic [PC_W-1:0] ds_pc;
  logic            ds_ready_go, stall;
  dec_t            dec;

  alu_op_decoder u_dec (.inst(ds_inst), .dec(dec));

  logic [4:0] rj, rk, rd;
  assign rj = ds_inst[9:5];
  assign rk = ds_inst[14:10];
  assign rd = ds_inst[4:0];
  assign rf_raddr1 = rj;
  assign rf_raddr2 = rk;

  logic rj_ex, rj_mem, rj_wb, rk_ex, rk_mem, rk_wb;
  assign rj_ex  = dec.rj_used & reg_hit(rj, ex_dest);
  assign rj_mem = dec.rj_used & reg_hit(rj, mem_dest);
  assign rj_wb  = dec.rj_used & reg_hit(rj, wb_dest);
  assign rk_ex  = dec.rk_used & reg_hit(rk, ex_dest);
  assign rk_mem = dec.rk_used & reg_hit(rk, mem_dest);
  assign rk_wb  = dec.rk_used & reg_hit(rk, wb_dest);

  logic [31:0] rj_data, rk_data;
`ifdef FORWARD_EN
  assign stall   = 1'b0;
  assign rj_data = rj_ex ? ex_fwd : rj_mem ? mem_fwd : rj_wb ? wb_fwd : rf_rdata1;
  assign rk_data = rk_ex ? ex_fwd : rk_mem ? mem_fwd : rk_wb ? wb_fwd : rf_rdata2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_fwd, mem_fwd, wb_fwd};
  assign stall   = ds_valid & (rj_ex | rj_mem | rj_wb | rk_ex | rk_mem | rk_wb);
  assign rj_data = rf_rdata1;
  assign rk_data = rf_rdata2;
`endif

  assign ds_ready_go       = ~stall;
  assign ds_allowin        = ~ds_valid | (ds_ready_go & es.es_allowin);
  assign es.ds_to_es_valid = ds_valid & ds_ready_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid <= 1'b0;
      ds_inst  <= '0;
      ds_pc    <= '0;
    end else if (flush) begin
      ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        ds_inst <= fs_inst;
        ds_pc   <= fs_pc;
      end
    end
  end

  assign es.alu_op   = ds_valid ? dec.alu_op : '0;
  assign es.gr_we    = ds_valid & dec.gr_we;
  assign es.inst_ine = ds_valid & dec.ine;
  assign es.dest     = es.gr_we ? rd : '0;
  assign es.ds_pc    = ds_pc;
  assign es.alu_src1 = dec.src1_pc ? ds_pc : rj_data;
  assign es.alu_src2 = dec.src2_imm ? dec.imm : rk_data;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; expectations are hand-decoded encodings.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        fs_to_ds_valid, ds_allowin, flush;
  logic [31:0] fs_inst, fs_pc;
  logic [4:0]  rf_raddr1, rf_raddr2, ex_dest, mem_dest, wb_dest;
  logic [31:0] rf_rdata1, rf_rdata2, ex_fwd, mem_fwd, wb_fwd;
  logic [31:0] rf [32];
  int checks = 0;
  int errors = 0;

  alu_issue_stage_if es_if ();

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .fs_to_ds_valid(fs_to_ds_valid), .ds_allowin(ds_allowin),
    .fs_inst(fs_inst), .fs_pc(fs_pc), .flush(flush),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
    .ex_fwd(ex_fwd), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd), .es(es_if)
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = (rf_raddr1 == 5'd0) ? 32'd0 : rf[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == 5'd0) ? 32'd0 : rf[rf_raddr2];

  task automatic load(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1; fs_inst = inst; fs_pc = pc;
    @(posedge clk); #1;
    fs_to_ds_valid = 1'b0;
  endtask

  task automatic drain;
    es_if.es_allowin = 1'b1; ex_dest = 0; mem_dest = 0; wb_dest = 0; flush = 1'b0;
    fs_to_ds_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", es_if.ds_to_es_valid); end
    checks++; if (ds_allowin !== 1'b1) begin errors++; $display("FAIL rst_allowin got %b exp 1", ds_allowin); end
    checks++; if (es_if.alu_op !== 12'h000) begin errors++; $display("FAIL rst_op got %h exp 000", es_if.alu_op); end
    checks++; if (es_if.gr_we !== 1'b0 || es_if.inst_ine !== 1'b0) begin errors++; $display("FAIL rst_we_ine got %b%b exp 00", es_if.gr_we, es_if.inst_ine); end
    checks++; if (es_if.ds_pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 0", es_if.ds_pc); end
  endtask

  task automatic test_add;
    load(32'h00100823, 32'h1C000004);
    checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", es_if.ds_to_es_valid); end
    checks++; if (es_if.alu_op !== 12'h001) begin errors++; $display("FAIL add_op got %h exp 001", es_if.alu_op); end
    checks++; if (es_if.alu_src1 !== 32'd5) begin errors++; $display("FAIL add_src1 got %h exp 5", es_if.alu_src1); end
    checks++; if (es_if.alu_src2 !== 32'd7) begin errors++; $display("FAIL add_src2 got %h exp 7", es_if.alu_src2); end
    checks++; if (es_if.dest !== 5'd3 || es_if.gr_we !== 1'b1) begin errors++; $display("FAIL add_dest got %0d/%b exp 3/1", es_if.dest, es_if.gr_we); end
    checks++; if (es_if.ds_pc !== 32'h1C000004) begin errors++; $display("FAIL add_pc got %h exp 1c000004", es_if.ds_pc); end
    @(posedge clk); #1;
    checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got %b exp 0", es_if.ds_to_es_valid); end
    // add.w r0,r1,r2: decoded but no register write
    load(32'h00100820, 32'h1C000008);
    checks++; if (es_if.alu_op !== 12'h001 || es_if.gr_we !== 1'b0 || es_if.dest !== 5'd0) begin errors++; $display("FAIL add_r0 got %h/%b/%0d exp 001/0/0", es_if.alu_op, es_if.gr_we, es_if.dest); end
    drain();
  endtask

  task automatic test_imm;
    load(32'h142468A4, 32'h1C000010);
    checks++; if (es_if.alu_op !== 12'h800) begin errors++; $display("FAIL lui_op got %h exp 800", es_if.alu_op); end
    checks++; if (es_if.alu_src2 !== 32'h12345000) begin errors++; $display("FAIL lui_src2 got %h exp 12345000", es_if.alu_src2); end
    checks++; if (es_if.dest !== 5'd4) begin errors++; $display("FAIL lui_dest got %0d exp 4", es_if.dest); end
    load(32'h00488CC5, 32'h1C000014);
    checks++; if (es_if.alu_op !== 12'h400) begin errors++; $display("FAIL srai_op got %h exp 400", es_if.alu_op); end
    checks++; if (es_if.alu_src2 !== 32'd3 || es_if.alu_src1 !== 32'h80000000) begin errors++; $display("FAIL srai_src got %h/%h exp 80000000/3", es_if.alu_src1, es_if.alu_src2); end
    load(32'h02BFFC01, 32'h1C000018);
    checks++; if (es_if.alu_op !== 12'h001) begin errors++; $display("FAIL addi_op got %h exp 001", es_if.alu_op); end
    checks++; if (es_if.alu_src2 !== 32'hFFFFFFFF || es_if.alu_src1 !== 32'd0) begin errors++; $display("FAIL addi_src got %h/%h exp 0/ffffffff", es_if.alu_src1, es_if.alu_src2); end
    load(32'h037FFC22, 32'h1C00001C);
    checks++; if (es_if.alu_op !== 12'h010 || es_if.alu_src2 !== 32'h00000FFF) begin errors++; $display("FAIL andi got %h/%h exp 010/00000fff", es_if.alu_op, es_if.alu_src2); end
    load(32'h1C000027, 32'h1C000100);
    checks++; if (es_if.alu_op !== 12'h001 || es_if.alu_src1 !== 32'h1C000100 || es_if.alu_src2 !== 32'h00001000) begin errors++; $display("FAIL pcadd got %h/%h/%h exp 001/1c000100/00001000", es_if.alu_op, es_if.alu_src1, es_if.alu_src2); end
    checks++; if (es_if.dest !== 5'd7) begin errors++; $display("FAIL pcadd_dest got %0d exp 7", es_if.dest); end
    drain();
  endtask

  task automatic test_hazard;
`ifdef FORWARD_EN
    ex_dest = 5'd1; ex_fwd = 32'h111; mem_dest = 5'd1; mem_fwd = 32'h222;
    wb_dest = 5'd2; wb_fwd = 32'h333;
    load(32'h00100823, 32'h1C000200);
    checks++; if (es_if.ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b1) begin errors++; $display("FAIL fwd_nostall got %b/%b exp 1/1", es_if.ds_to_es_valid, ds_allowin); end
    checks++; if (es_if.alu_src1 !== 32'h111) begin errors++; $display("FAIL fwd_ex got %h exp 111", es_if.alu_src1); end
    checks++; if (es_if.alu_src2 !== 32'h333) begin errors++; $display("FAIL fwd_wb got %h exp 333", es_if.alu_src2); end
    ex_dest = 5'd0; #1;
    checks++; if (es_if.alu_src1 !== 32'h222) begin errors++; $display("FAIL fwd_mem got %h exp 222", es_if.alu_src1); end
    drain();
`else
    ex_dest = 5'd1;
    load(32'h00100823, 32'h1C000200);
    for (int i = 0; i < 2; i++) begin
      checks++; if (es_if.ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b0) begin errors++; $display("FAIL stall_ex%0d got %b/%b exp 0/0", i, es_if.ds_to_es_valid, ds_allowin); end
      @(posedge clk); #1;
    end
    ex_dest = 5'd0; #1;
    checks++; if (es_if.ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b1) begin errors++; $display("FAIL stall_release got %b/%b exp 1/1", es_if.ds_to_es_valid, ds_allowin); end
    @(posedge clk); #1;
    checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL stall_issued got %b exp 0", es_if.ds_to_es_valid); end
    wb_dest = 5'd2;
    load(32'h00100823, 32'h1C000204);
    checks++; if (es_if.ds_to_es_valid !== 1'b0) begin errors++; $display("FAIL stall_wb_rk got %b exp 0", es_if.ds_to_es_valid); end
    drain();
`endif
    // lu12i reads no source, so a matching rj field must not stall
    ex_dest = 5'd5;
    load(32'h142468A4, 32'h1C000208);
    checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL lui_nostall got %b exp 1", es_if.ds_to_es_valid); end
    drain();
  endtask

  task automatic test_hold_flush;
    es_if.es_allowin = 1'b0;
    load(32'h00100823, 32'h1C000300);
    fs_to_ds_valid = 1'b1; fs_inst = 32'hFFFFFFFF; fs_pc = 32'h1C000400;
    for (int i = 0; i < 3; i++) begin
      checks++; if (es_if.ds_to_es_valid !== 1'b1 || ds_allowin !== 1'b0) begin errors++; $display("FAIL hold_hs%0d got %b/%b exp 1/0", i, es_if.ds_to_es_valid, ds_allowin); end
      checks++; if (es_if.alu_op !== 12'h001 || es_if.alu_src1 !== 32'd5 || es_if.alu_src2 !== 32'd7 || es_if.ds_pc !== 32'h1C000300) begin errors++; $display("FAIL hold_data%0d got %h/%h/%h/%h", i, es_if.alu_op, es_if.alu_src1, es_if.alu_src2, es_if.ds_pc); end
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; fs_to_ds_valid = 1'b0;
    checks++; if (es_if.ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin errors++; $display("FAIL flush got %b/%b exp 0/1", es_if.ds_to_es_valid, ds_allowin); end
    checks++; if (es_if.inst_ine !== 1'b0 || es_if.ds_pc !== 32'h1C000300) begin errors++; $display("FAIL flush_drop got %b/%h exp 0/1c000300", es_if.inst_ine, es_if.ds_pc); end
    drain();
  endtask

  task automatic test_ine;
    load(32'hFFFFFFFF, 32'h1C000500);
    checks++; if (es_if.inst_ine !== 1'b1) begin errors++; $display("FAIL ine_flag got %b exp 1", es_if.inst_ine); end
    checks++; if (es_if.alu_op !== 12'h000 || es_if.gr_we !== 1'b0 || es_if.dest !== 5'd0) begin errors++; $display("FAIL ine_op got %h/%b/%0d exp 000/0/0", es_if.alu_op, es_if.gr_we, es_if.dest); end
    checks++; if (es_if.ds_to_es_valid !== 1'b1) begin errors++; $display("FAIL ine_issue got %b exp 1", es_if.ds_to_es_valid); end
    drain();
  endtask

  task automatic test_reset_mid_stall;
    es_if.es_allowin = 1'b0; ex_dest = 5'd1;
    load(32'h00100823, 32'h1C000600);
    checks++; if (ds_allowin !== 1'b0) begin errors++; $display("FAIL mid_blocked got %b exp 0", ds_allowin); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (es_if.ds_to_es_valid !== 1'b0 || ds_allowin !== 1'b1) begin errors++; $display("FAIL mid_reset got %b/%b exp 0/1", es_if.ds_to_es_valid, ds_allowin); end
    checks++; if (es_if.ds_pc !== 32'h0) begin errors++; $display("FAIL mid_reset_pc got %h exp 0", es_if.ds_pc); end
    drain();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rf[1] = 32'd5; rf[2] = 32'd7; rf[6] = 32'h80000000;
    fs_to_ds_valid = 1'b0; fs_inst = 32'h0; fs_pc = 32'h0; flush = 1'b0;
    ex_dest = 0; mem_dest = 0; wb_dest = 0;
    ex_fwd = 32'h0; mem_fwd = 32'h0; wb_fwd = 32'h0;
    es_if.es_allowin = 1'b1;
    test_reset();
    test_add();
    test_imm();
    test_hazard();
    test_hold_flush();
    test_ine();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue pipeline stage that produces operands for the EX-stage ALU. It latches one instruction and PC from IF under the valid/allowin handshake and decodes the LoongArch32 integer ALU subset into the 12-bit one-hot alu_op. It reads the register file, selects alu_src1/alu_src2 and detects RAW hazards. It then issues the result to EX under the same handshake.

Parameters:
- PC_W, 32, PC / data width (fixed at 32 for LA32)
- NREG_LOG, 5, register index width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- fs_to_ds_valid  in  1  IF holds a valid instruction
- ds_allowin  out  1  this stage can accept an instruction this cycle
- fs_inst  in  32  instruction word
- fs_pc  in  32  instruction PC
- flush  in  1  discard the held instruction
- rf_raddr1 / rf_raddr2  out  5  register file read addresses (rj / rk)
- rf_rdata1 / rf_rdata2  in  32  register file read data (r0 reads 0)
- ex_dest, mem_dest, wb_dest  in  5 each  destination of the downstream stage; 0 = none
- ex_fwd, mem_fwd, wb_fwd  in  32 each  downstream results (used only under FORWARD_EN)
- es_allowin  in  1  EX can accept
- ds_to_es_valid  out  1  issue valid
- alu_op  out  12  one-hot: add0 sub1 slt2 sltu3 and4 nor5 or6 xor7 sll8 srl9 sra10 lui11
- alu_src1 / alu_src2  out  32 each  ALU operands
- ds_pc  out  32  PC of the issued instruction
- dest  out  5  write register; 0 when no write
- gr_we  out  1  register write enable
- inst_ine  out  1  instruction not in the supported subset

Behaviour:
- Registers: ds_valid, ds_inst, ds_pc. Reset sets all to 0.
- ds_ready_go = ~stall. ds_allowin = ~ds_valid | (ds_ready_go & es_allowin). ds_to_es_valid = ds_valid & ds_ready_go.
- Latch: when fs_to_ds_valid & ds_allowin, load inst/pc and set ds_valid=1. When ds_allowin with no input, clear ds_valid.
- Flush: ds_valid=0 next cycle and an incoming instruction is dropped. Flush has priority over latch. Reset has priority over everything.
- Decode fields: rd[4:0], rj[9:5], rk[14:10].
  - 3R ops have inst[31:22]=0 and inst[21:20]=01. inst[19:15] selects: add 00000, sub 00010, slt 00100, sltu 00101, nor 01000, and 01001, or 01010, xor 01011, sll 01110, srl 01111, sra 10000.
  - Shift-immediate ops have inst[31:26]=0, inst[25:22]=0001, inst[21:20]=00. inst[19:15] selects: slli 00001, srli 01001, srai 10001.
  - 2RI12 ops have inst[31:26]=0. inst[25:22] selects: slti 1000, sltui 1001, addi 1010, andi 1101, ori 1110, xori 1111.
  - 1RI20 ops: inst[31:25] 0001010 = lu12i.w, 0001110 = pcaddu12i.
- Immediates:
  - si12 is sign-extended (addi/slti/sltui).
  - ui12 is zero-extended (andi/ori/xori).
  - ui5 = inst[14:10] (shift-immediate ops).
  - si20 is placed in bits [31:12] with zero low bits (lu12i/pcaddu12i).
- Operand selection:
  - src1 = pc for pcaddu12i, otherwise rj data.
  - src2 = immediate for all immediate forms, otherwise rk data.
  - lu12i uses op bit 11; pcaddu12i uses op bit 0.
- Read use: rk is read only for 3R ops; rj is read for all ops except lu12i/pcaddu12i.
- gr_we = decoded & (rd != 0). dest = gr_we ? rd : 0.
- Unsupported encoding: inst_ine=1, alu_op=0, gr_we=0. The instruction is still issued through the handshake.
- When ds_valid=0: alu_op=0, gr_we=0, inst_ine=0.
- Stall: asserted when a used source register (non-zero) equals ex_dest, mem_dest or wb_dest. Index 0 never stalls.
- Hold: while ds_valid & ~(ds_ready_go & es_allowin), all outputs stay stable.

Optional Feature:
- Macro FORWARD_EN.
- Defined:
  - A source matching a downstream dest takes that stage's data instead of stalling.
  - Priority is ex > mem > wb. stall = 0.
- Undefined:
  - A match stalls as described under Behaviour. *_fwd inputs are ignored.

Decomposition:
- Shared package alu_defs_pkg holds the ALU_OP_* bit indices, the opcode/func constants, and the alu_op width.
- One sub-module, alu_op_decoder: combinational inst → {alu_op, imm, src-select, rj_used, rk_used, gr_we, ine}.

Test Plan:
- add.w r3,r1,r2 = 0x00100823, rf r1=5, r2=7 → alu_op=12'h001, src1=5, src2=7, dest=3, gr_we=1; issue one cycle after latch.
- lu12i.w r4,0x12345 = 0x142468A4 → alu_op=12'h800, src2=0x12345000, dest=4.
- srai.w r5,r6,3 = 0x00488CC5 → alu_op=12'h400, src2=3. addi.w r1,r0,-1 = 0x02BFFC01 → alu_op=12'h001, src2=0xFFFFFFFF.
- add.w 0x00100823 with ex_dest=1 for 2 cycles → ds_to_es_valid=0 and ds_allowin=0 for those cycles. Issues the cycle ex_dest=0. Under FORWARD_EN: no stall and src1=ex_fwd.
- es_allowin=0 for 3 cycles → outputs held constant. Flush during the hold → ds_to_es_valid=0 next cycle.
- inst 0xFFFFFFFF → inst_ine=1, alu_op=0, gr_we=0. reset asserted mid-stall → ds_to_es_valid=0 and ds_allowin=1 after the reset cycle.
